// File: rtl/alu_sched_pkg.sv
// Shared definitions for the vector ALU sequencing controller:
// function codes, ALU opcode values, lane-width encodings and FSM states.
package alu_sched_pkg;

  // Width of the latency count carried from decoder to scheduler
  localparam int LAT_W = 8;

  // Opcode presented to the ALU while an operation is executing
  localparam logic [5:0] OPC_VEC  = 6'b101010;
  localparam logic [5:0] OPC_NONE = 6'b000000;

  // R_ins function codes
  localparam logic [5:0] RINS_VAND   = 6'b000001;
  localparam logic [5:0] RINS_VOR    = 6'b000010;
  localparam logic [5:0] RINS_VXOR   = 6'b000011;
  localparam logic [5:0] RINS_VNOT   = 6'b000100;
  localparam logic [5:0] RINS_VMOV   = 6'b000101;
  localparam logic [5:0] RINS_VADD   = 6'b000110;
  localparam logic [5:0] RINS_VSUB   = 6'b000111;
  localparam logic [5:0] RINS_VMULEU = 6'b001000;
  localparam logic [5:0] RINS_VMULOU = 6'b001001;
  localparam logic [5:0] RINS_VSLL   = 6'b001010;
  localparam logic [5:0] RINS_VSRL   = 6'b001011;
  localparam logic [5:0] RINS_VSRA   = 6'b001100;
  localparam logic [5:0] RINS_VRTTH  = 6'b001101;
  localparam logic [5:0] RINS_VDIV   = 6'b001110;
  localparam logic [5:0] RINS_VMOD   = 6'b001111;
  localparam logic [5:0] RINS_VSQEU  = 6'b010000;
  localparam logic [5:0] RINS_VSQOU  = 6'b010001;
  localparam logic [5:0] RINS_VSQRT  = 6'b010010;

  // Lane width encodings
  localparam logic [1:0] WW_8  = 2'b00;
  localparam logic [1:0] WW_16 = 2'b01;
  localparam logic [1:0] WW_32 = 2'b10;
  localparam logic [1:0] WW_64 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sched_if.sv
// Requester and response channels of the ALU scheduler.
// master: the issue side (drives requests, consumes responses).
// slave:  the scheduler.
interface alu_sched_if;

  logic        req0_valid;
  logic        req0_ready;
  logic [0:63] req0_rA;
  logic [0:63] req0_rB;
  logic [0:5]  req0_rins;
  logic [0:1]  req0_ww;

  logic        req1_valid;
  logic        req1_ready;
  logic [0:63] req1_rA;
  logic [0:63] req1_rB;
  logic [0:5]  req1_rins;
  logic [0:1]  req1_ww;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:63] rsp_data;
  logic        rsp_id;
  logic        rsp_err;

  modport master (
    output req0_valid, req0_rA, req0_rB, req0_rins, req0_ww,
    input  req0_ready,
    output req1_valid, req1_rA, req1_rB, req1_rins, req1_ww,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_rA, req0_rB, req0_rins, req0_ww,
    output req0_ready,
    input  req1_valid, req1_rA, req1_rB, req1_rins, req1_ww,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_lat_decode.sv
// Combinational R_ins decoder: number of cycles the operands must be held
// on the ALU inputs, and whether the function code is unsupported.
module alu_lat_decode
  import alu_sched_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 8,
  parameter int SQRT_LAT = 16
) (
  input  logic [0:5]       rins,
  output logic [LAT_W-1:0] lat,
  output logic             illegal
);

  // Map each function code onto its latency class
  always_comb begin
    lat     = LAT_W'(1);
    illegal = 1'b0;
    case (rins)
      RINS_VAND, RINS_VOR, RINS_VXOR, RINS_VNOT, RINS_VMOV, RINS_VADD,
      RINS_VSUB, RINS_VSLL, RINS_VSRL, RINS_VSRA, RINS_VRTTH:
        lat = LAT_W'(1);
      RINS_VMULEU, RINS_VMULOU, RINS_VSQEU, RINS_VSQOU:
        lat = LAT_W'(MUL_LAT);
      RINS_VDIV, RINS_VMOD:
        lat = LAT_W'(DIV_LAT);
      RINS_VSQRT:
        lat = LAT_W'(SQRT_LAT);
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Sequencing controller for the shared 64-bit vector ALU.
// Two requesters are arbitrated round-robin; the granted operands are held
// on the ALU inputs for the function's latency, then the ALU result is
// returned on a valid/ready response tagged with the requester id.
// Optional feature: define ALU_SCHED_DIVZERO_CHK_EN to reject VDIV/VMOD
// whose rB has any zero lane (error response with all-ones data).
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 8,
  parameter int SQRT_LAT = 16
) (
  input  logic        clk,
  input  logic        reset,
  alu_sched_if.slave  bus,
  output logic [0:63] alu_rA,
  output logic [0:63] alu_rB,
  output logic [0:5]  alu_rins,
  output logic [0:5]  alu_opcode,
  output logic [0:1]  alu_ww,
  input  logic [0:63] alu_out
);

  state_t           state;
  logic             last_grant;
  logic             cur_id;
  logic [LAT_W-1:0] cnt;

  logic             rsp_valid;
  logic [0:63]      rsp_data;
  logic             rsp_id;
  logic             rsp_err;

  logic             grant_id;
  logic             accept;
  logic [0:63]      sel_rA;
  logic [0:63]      sel_rB;
  logic [0:5]       sel_rins;
  logic [0:1]       sel_ww;
  logic [LAT_W-1:0] sel_lat;
  logic             sel_illegal;
  logic             div_zero;

  // Round-robin arbiter; readys depend only on state, valids and last_grant
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant_id = ~last_grant;
    else                                  grant_id = bus.req1_valid;
    accept = !reset && (state == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
    bus.req0_ready = accept && !grant_id;
    bus.req1_ready = accept &&  grant_id;
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_rA   = grant_id ? bus.req1_rA   : bus.req0_rA;
    sel_rB   = grant_id ? bus.req1_rB   : bus.req0_rB;
    sel_rins = grant_id ? bus.req1_rins : bus.req0_rins;
    sel_ww   = grant_id ? bus.req1_ww   : bus.req0_ww;
  end

  alu_lat_decode #(
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT),
    .SQRT_LAT (SQRT_LAT)
  ) u_lat_decode (
    .rins    (sel_rins),
    .lat     (sel_lat),
    .illegal (sel_illegal)
  );

`ifdef ALU_SCHED_DIVZERO_CHK_EN
  // True when any lane of width ww in v is all zeros
  function automatic logic has_zero_lane(input logic [0:63] v, input logic [0:1] ww);
    logic z;
    z = 1'b0;
    case (ww)
      WW_8:    for (int i = 0; i < 8; i++) if (v[8*i +: 8]   == '0) z = 1'b1;
      WW_16:   for (int i = 0; i < 4; i++) if (v[16*i +: 16] == '0) z = 1'b1;
      WW_32:   for (int i = 0; i < 2; i++) if (v[32*i +: 32] == '0) z = 1'b1;
      default: if (v == '0) z = 1'b1;
    endcase
    return z;
  endfunction

  assign div_zero = ((sel_rins == RINS_VDIV) || (sel_rins == RINS_VMOD)) &&
                    has_zero_lane(sel_rB, sel_ww);
`else
  assign div_zero = 1'b0;
`endif

  // Scheduler FSM with registered ALU drive and response register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      cnt        <= '0;
      alu_rA     <= '0;
      alu_rB     <= '0;
      alu_rins   <= '0;
      alu_ww     <= '0;
      alu_opcode <= OPC_NONE;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_grant <= grant_id;
            cur_id     <= grant_id;
            if (sel_illegal || div_zero) begin
              // Rejected without touching the ALU
              rsp_valid <= 1'b1;
              rsp_id    <= grant_id;
              rsp_err   <= 1'b1;
              rsp_data  <= sel_illegal ? 64'h0 : {64{1'b1}};
              state     <= ST_DONE;
            end else begin
              alu_rA     <= sel_rA;
              alu_rB     <= sel_rB;
              alu_rins   <= sel_rins;
              alu_ww     <= sel_ww;
              alu_opcode <= OPC_VEC;
              cnt        <= sel_lat - LAT_W'(1);
              state      <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= alu_out;
            rsp_id     <= cur_id;
            rsp_err    <= 1'b0;
            alu_opcode <= OPC_NONE;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response channel outputs come straight from the registers
  always_comb begin
    bus.rsp_valid = rsp_valid;
    bus.rsp_data  = rsp_data;
    bus.rsp_id    = rsp_id;
    bus.rsp_err   = rsp_err;
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small behavioural ALU stub.
module tb_alu_sched;
  import alu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:63] alu_rA, alu_rB, alu_out;
  logic [0:5]  alu_rins, alu_opcode;
  logic [0:1]  alu_ww;

  int n_chk  = 0;
  int n_pass = 0;

  alu_sched_if bus ();

  alu_sched #(.MUL_LAT(2), .DIV_LAT(8), .SQRT_LAT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .alu_rA     (alu_rA),
    .alu_rB     (alu_rB),
    .alu_rins   (alu_rins),
    .alu_opcode (alu_opcode),
    .alu_ww     (alu_ww),
    .alu_out    (alu_out)
  );

  always #5 clk = ~clk;

  // ALU stub: a few real functions, xor for the rest, a marker when idle
  always_comb begin
    alu_out = 64'hDEAD_BEEF_DEAD_BEEF;
    if (alu_opcode == OPC_VEC) begin
      case (alu_rins)
        RINS_VAND: alu_out = alu_rA & alu_rB;
        RINS_VOR:  alu_out = alu_rA | alu_rB;
        RINS_VADD: alu_out = alu_rA + alu_rB;
        default:   alu_out = alu_rA ^ alu_rB;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted (bounded); ends just after the accept edge
  task automatic send(input bit id, input logic [5:0] rins, input logic [1:0] ww,
                      input logic [63:0] ra, input logic [63:0] rb);
    int  n;
    bit  got;
    if (id) begin
      bus.req1_rA = ra; bus.req1_rB = rb; bus.req1_rins = rins; bus.req1_ww = ww;
      bus.req1_valid = 1'b1;
    end else begin
      bus.req0_rA = ra; bus.req0_rB = rb; bus.req0_rins = rins; bus.req0_ww = ww;
      bus.req0_valid = 1'b1;
    end
    n = 0; got = 0;
    while (!got && n < 40) begin
      #1;
      if (id ? bus.req1_ready : bus.req0_ready) got = 1;
      else begin tick(); n++; end
    end
    if (!got) chk("accept_timeout", 64'(got), 64'd1);
    tick();
    if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
  endtask

  // Count edges after the accept edge until rsp_valid is seen (bounded)
  task automatic wait_rsp(output int c);
    c = 0;
    while (!bus.rsp_valid && c < 100) begin
      tick();
      c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          c;
    bit          stable;
    logic [63:0] d_hold;
    logic        id_hold, err_hold;

    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 0; bus.req0_rA = 0; bus.req0_rB = 0; bus.req0_rins = 0; bus.req0_ww = 0;
    bus.req1_valid = 0; bus.req1_rA = 0; bus.req1_rB = 0; bus.req1_rins = 0; bus.req1_ww = 0;
    tick(); tick();

    // Reset state, both requesters already waiting
    bus.req0_rA = 64'd5;  bus.req0_rB = 64'd10; bus.req0_rins = RINS_VADD; bus.req0_ww = WW_32;
    bus.req1_rA = 64'd15; bus.req1_rB = 64'd14; bus.req1_rins = RINS_VOR;  bus.req1_ww = WW_32;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
    chk("rst_ready1", 64'(bus.req1_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_rsp_id_err", {62'd0, bus.rsp_id, bus.rsp_err}, 64'd0);
    chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);
    chk("rst_alu_rA", alu_rA, 64'd0);

    // Contention right after reset: req0 wins first
    tick();
    reset = 1'b0;
    #1;
    chk("cont_ready0", 64'(bus.req0_ready), 64'd1);
    chk("cont_ready1", 64'(bus.req1_ready), 64'd0);
    tick();
    bus.req0_valid = 1'b0;
    chk("cont_exec_opcode", 64'(alu_opcode), 64'h2A);
    chk("cont_exec_ready1", 64'(bus.req1_ready), 64'd0);
    wait_rsp(c);
    chk("cont0_lat", 64'(c), 64'd1);
    chk("cont0_data", bus.rsp_data, 64'd15);
    chk("cont0_id", 64'(bus.rsp_id), 64'd0);
    tick();
    chk("cont_done_exit_valid", 64'(bus.rsp_valid), 64'd0);
    chk("cont_ready1_next", 64'(bus.req1_ready), 64'd1);
    tick();
    bus.req1_valid = 1'b0;
    wait_rsp(c);
    chk("cont1_lat", 64'(c), 64'd1);
    chk("cont1_data", bus.rsp_data, 64'd15);
    chk("cont1_id", 64'(bus.rsp_id), 64'd1);
    chk("cont1_err", 64'(bus.rsp_err), 64'd0);
    tick();

    // Single-cycle op
    send(0, RINS_VAND, WW_32, 64'd15, 64'd14);
    wait_rsp(c);
    chk("vand_lat", 64'(c), 64'd1);
    chk("vand_data", bus.rsp_data, 64'd14);
    chk("vand_id", 64'(bus.rsp_id), 64'd0);
    chk("vand_err", 64'(bus.rsp_err), 64'd0);
    tick();
    chk("vand_back_idle", {62'd0, bus.rsp_valid, alu_opcode == OPC_VEC}, 64'd0);

    // Multiply class latency
    send(1, RINS_VMULEU, WW_16, 64'd3, 64'd5);
    wait_rsp(c);
    chk("mul_lat", 64'(c), 64'd2);
    chk("mul_data", bus.rsp_data, 64'd6);
    tick();

    // Long-latency divide with operand stability
    send(0, RINS_VDIV, WW_8, 64'hFF00FF00_FF00FF00, 64'h11221122_44444444);
    c = 0; stable = 1;
    while (!bus.rsp_valid && c < 100) begin
      if (alu_rA !== 64'hFF00FF00_FF00FF00 || alu_rB !== 64'h11221122_44444444 ||
          alu_rins !== RINS_VDIV || alu_opcode !== OPC_VEC) stable = 0;
      tick();
      c++;
    end
    chk("div_lat", 64'(c), 64'd8);
    chk("div_stable", 64'(stable), 64'd1);
    chk("div_data", bus.rsp_data, 64'hEE22EE22_BB44BB44);
    chk("div_err", 64'(bus.rsp_err), 64'd0);
    chk("div_opcode_after", 64'(alu_opcode), 64'd0);
    chk("div_rA_held", alu_rA, 64'hFF00FF00_FF00FF00);
    tick();

    // Backpressure on a square root
    bus.rsp_ready = 1'b0;
    send(1, RINS_VSQRT, WW_16, 64'h00000640_00040001, 64'd0);
    wait_rsp(c);
    chk("sqrt_lat", 64'(c), 64'd16);
    d_hold = bus.rsp_data; id_hold = bus.rsp_id; err_hold = bus.rsp_err;
    bus.req0_valid = 1'b1; bus.req0_rins = RINS_VAND;
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      if (!bus.rsp_valid || bus.rsp_data !== d_hold || bus.rsp_id !== id_hold ||
          bus.rsp_err !== err_hold || bus.req0_ready || bus.req1_ready) stable = 0;
      tick();
    end
    chk("bp_frozen", 64'(stable), 64'd1);
    chk("bp_data", bus.rsp_data, 64'h00000640_00040001);
    chk("bp_id_err", {62'd0, bus.rsp_id, bus.rsp_err}, 64'd2);
    bus.rsp_ready = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    chk("bp_release", 64'(bus.rsp_valid), 64'd0);
    tick();

    // Illegal function codes
    send(0, 6'b111111, WW_64, 64'd1, 64'd2);
    wait_rsp(c);
    chk("ill_lat", 64'(c), 64'd0);
    chk("ill_err", 64'(bus.rsp_err), 64'd1);
    chk("ill_data", bus.rsp_data, 64'd0);
    chk("ill_opcode", 64'(alu_opcode), 64'd0);
    tick();
    send(1, 6'b010011, WW_64, 64'd1, 64'd2);
    wait_rsp(c);
    chk("ill2_err_id", {62'd0, bus.rsp_id, bus.rsp_err}, 64'd3);
    tick();

    // Reset in the middle of a square root
    send(1, RINS_VSQRT, WW_16, 64'h1234, 64'd0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_opcode", 64'(alu_opcode), 64'd0);
    chk("mid_rst_rA", alu_rA, 64'd0);
    reset = 1'b0;
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) stable = 0;
      tick();
    end
    chk("mid_rst_no_rsp", 64'(stable), 64'd1);
    send(0, RINS_VXOR, WW_64, 64'hF0, 64'hFF);
    wait_rsp(c);
    chk("post_rst_data", bus.rsp_data, 64'h0F);
    tick();

    // Divide by a zero lane
    send(0, RINS_VMOD, WW_32, 64'h12345678_9ABCDEF0, 64'h00000005_00000000);
    wait_rsp(c);
`ifdef ALU_SCHED_DIVZERO_CHK_EN
    chk("dz_lat", 64'(c), 64'd0);
    chk("dz_err", 64'(bus.rsp_err), 64'd1);
    chk("dz_data", bus.rsp_data, 64'hFFFFFFFF_FFFFFFFF);
`else
    chk("dz_lat", 64'(c), 64'd8);
    chk("dz_err", 64'(bus.rsp_err), 64'd0);
    chk("dz_data", bus.rsp_data, 64'h1234567D_9ABCDEF0);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
